cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) between the four execution result producers: ALU, load (MEM), MUL and DIV. Each producer pushes a result (value, PC, physical tag) into a private holding FIFO. A round-robin arbiter selects one non-empty FIFO per cycle and drives a registered CDB broadcast to the reservation stations and the physical register file. The block sits between the EX/MEM and MEM/WB stage outputs and the wakeup/writeback logic.

Parameters:
DEPTH, 2, entries per source holding FIFO; power of two, minimum 2
TAG_W, 8, physical register tag width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; asserted when 0
flush  input  1  synchronous clear of all pending results (mispredict recovery)
src_valid  input  4  per-source result valid; bit0 ALU, bit1 LOAD, bit2 MUL, bit3 DIV
src_value  input  128  four packed 32-bit result values, source i at bits [32i+31:32i]
src_pc  input  128  four packed 32-bit instruction PCs
src_tag  input  4*TAG_W  four packed destination physical tags
src_ready  output  4  per-source FIFO not full
cdb_valid  output  1  CDB broadcast valid
cdb_value  output  32  broadcast result
cdb_pc  output  32  broadcast PC
cdb_tag  output  TAG_W  broadcast physical tag
cdb_src  output  2  index of the granted source
err_overflow  output  1  sticky; set when src_valid[i] is asserted while src_ready[i]=0

Behaviour:
- Reset (reset=0, asynchronous): all FIFOs empty; cdb_valid=0; cdb_value=0; cdb_pc=0; cdb_tag=0; cdb_src=0; err_overflow=0; src_ready=4'b1111; round-robin last-grant pointer=3, so ALU has first priority.
- src_ready[i] = (count[i] != DEPTH). It is combinational from registered count only and has no input dependency.
- Enqueue: at a rising edge with src_valid[i] && src_ready[i], the {value, pc, tag} triple is written at the tail of FIFO i.
- Overflow: src_valid[i] && !src_ready[i] drops the input. err_overflow is set and stays set until reset.
- Arbitration: combinational over the non-empty flags of the FIFOs.
  - The search starts at (last+1) mod 4 and wraps; the first non-empty FIFO wins.
  - The winner's head is popped at the edge and registered onto the CDB.
  - last <= winner.
  - If no FIFO is non-empty, cdb_valid <= 0 and the data outputs hold their previous values.
- Only one grant per cycle. At most one broadcast per cycle.
- Latency: a result enqueued at edge N into an empty FIFO with no contention appears with cdb_valid=1 in the cycle after edge N+1, i.e. 2 cycles.
- Same-cycle enqueue and pop on the same FIFO: both occur and the count is unchanged. This is legal at any count < DEPTH, including count=DEPTH-1.
- A full FIFO that is popped does not accept the same-cycle input, because ready was 0.
- Pointers: head and tail are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Flush (synchronous, priority over everything except reset):
  - All counts <= 0 and cdb_valid <= 0.
  - Same-cycle src_valid inputs are discarded without setting err_overflow.
  - last <= 3.
  - err_overflow keeps its value.
- Reset asserted mid-operation clears everything immediately. Pending results are lost.

Optional Feature:
CDB_PERF_EN:
- Defined: adds output perf_conflict (16 bits) and output perf_stall (16 bits). Both reset to 0 and saturate at 16'hFFFF.
  - perf_conflict increments each cycle in which two or more FIFOs are non-empty.
  - perf_stall increments each cycle in which any src_valid[i] coincides with src_ready[i]=0.
  - flush does not clear either counter.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset release; pulse ALU valid for one cycle with value=32'h0000_0011, pc=32'h100, tag=8'h05 -> two cycles later, cdb_valid=1 for exactly 1 cycle with cdb_value=32'h11, cdb_pc=32'h100, cdb_tag=5, cdb_src=0.
- All four sources valid in the same cycle with values 1, 2, 3, 4 -> four consecutive broadcasts in order src 0, 1, 2, 3 (values 1, 2, 3, 4), then cdb_valid=0.
- MUL held valid for 3 cycles while ALU and LOAD are valid every cycle (DEPTH=2) -> src_ready[2] goes 0 once 2 MUL entries are queued; round-robin grants rotate 0, 1, 2; no entry is lost; err_overflow stays 0.
- Drive DIV valid while src_ready[3]=0 -> that input is never broadcast and err_overflow=1 until reset.
- Queue 3 results, then assert flush for 1 cycle together with a new ALU valid -> cdb_valid=0 from the next cycle onward and nothing is broadcast; the next fresh ALU result is granted first.
- Assert reset=0 mid-burst -> all outputs are 0 and src_ready=4'hF immediately, without waiting for a clk edge. With CDB_PERF_EN, 5 contention cycles read perf_conflict=5.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer result bus and registered CDB broadcast for cdb_arbiter
interface cdb_arbiter_if #(parameter int TAG_W = 8);
  logic [3:0]         src_valid;
  logic [127:0]       src_value;
  logic [127:0]       src_pc;
  logic [4*TAG_W-1:0] src_tag;
  logic [3:0]         src_ready;
  logic               cdb_valid;
  logic [31:0]        cdb_value;
  logic [31:0]        cdb_pc;
  logic [TAG_W-1:0]   cdb_tag;
  logic [1:0]         cdb_src;
  modport master (output src_valid, src_value, src_pc, src_tag,
                  input src_ready, cdb_valid, cdb_value, cdb_pc, cdb_tag, cdb_src);
  modport slave (input src_valid, src_value, src_pc, src_tag,
                 output src_ready, cdb_valid, cdb_value, cdb_pc, cdb_tag, cdb_src);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter over four producer FIFOs; CDB_PERF_EN adds perf_conflict/perf_stall counters
module cdb_arbiter #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  cdb_arbiter_if.slave bus,
  output logic         err_overflow
`ifdef CDB_PERF_EN
  ,
  output logic [15:0]  perf_conflict,
  output logic [15:0]  perf_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 64 + TAG_W;
  logic [EW-1:0] mem [4][DEPTH];
  logic [AW-1:0] head [4];
  logic [AW-1:0] tail [4];
  logic [CW-1:0] count [4];
  logic [3:0]    nonempty, ready, push, pop, drop;
  logic [1:0]    last, grant;
  logic          any;
  logic [EW-1:0] head_ent;
  always_comb begin
    nonempty = '0;
    ready = '0;
    for (int i = 0; i < 4; i++) begin
      nonempty[i] = count[i] != '0;
      ready[i] = count[i] != CW'(DEPTH);
    end
  end
  // scan from farthest to nearest so the first non-empty after last wins
  always_comb begin
    grant = last;
    for (int k = 4; k >= 1; k--)
      if (nonempty[last + 2'(k)]) grant = last + 2'(k);
  end
  assign any = |nonempty;
  assign push = bus.src_valid & ready & {4{!flush}};
  assign drop = bus.src_valid & ~ready;
  assign pop = any ? 4'(4'b1 << grant) : 4'b0;
  assign head_ent = mem[grant][head[grant]];
  assign bus.src_ready = ready;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (push[i]) mem[i][tail[i]] <= {bus.src_value[32*i +: 32], bus.src_pc[32*i +: 32], bus.src_tag[TAG_W*i +: TAG_W]};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        count[i] <= '0;
      end
      last <= 2'd3;
      bus.cdb_valid <= 1'b0;
      bus.cdb_value <= '0;
      bus.cdb_pc <= '0;
      bus.cdb_tag <= '0;
      bus.cdb_src <= '0;
      err_overflow <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 4; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        count[i] <= '0;
      end
      last <= 2'd3;
      bus.cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) tail[i] <= tail[i] + AW'(1);
        if (pop[i]) head[i] <= head[i] + AW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      bus.cdb_valid <= any;
      if (any) begin
        {bus.cdb_value, bus.cdb_pc, bus.cdb_tag} <= head_ent;
        bus.cdb_src <= grant;
        last <= grant;
      end
      if (|drop) err_overflow <= 1'b1;
    end
  end
`ifdef CDB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_conflict <= '0;
      perf_stall <= '0;
    end else begin
      if ($countones(nonempty) > 1 && perf_conflict != 16'hFFFF) perf_conflict <= perf_conflict + 16'd1;
      if (|drop && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter (DEPTH=2, TAG_W=8)
module tb_cdb_arbiter;
  localparam int DEPTH = 2;
  localparam int TAG_W = 8;
  typedef struct packed {
    logic [31:0]      v;
    logic [31:0]      p;
    logic [TAG_W-1:0] t;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic err_overflow;
`ifdef CDB_PERF_EN
  logic [15:0] perf_conflict, perf_stall;
`endif
  int tests = 0;
  int fails = 0;
  ent_t sbq [4][$];
  logic [1:0] got [$];
  logic [3:0] acc;
  int mul_n;
  cdb_arbiter_if #(.TAG_W(TAG_W)) bus ();
  cdb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus.slave),
    .err_overflow(err_overflow)
`ifdef CDB_PERF_EN
    ,
    .perf_conflict(perf_conflict),
    .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // drive one cycle at the falling edge; record expected entries the DUT must accept
  task automatic cyc(input logic [3:0] v, input logic fl, input logic gate, input logic rec,
                     input logic [31:0] vb, input logic [31:0] pb, input logic [7:0] tb_);
    logic [3:0] drv;
    @(negedge clk);
    flush = fl;
    drv = gate ? (v & bus.src_ready) : v;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      bus.src_valid[i] = drv[i];
      bus.src_value[32*i +: 32] = vb + 32'(i);
      bus.src_pc[32*i +: 32] = pb + 32'(4*i);
      bus.src_tag[TAG_W*i +: TAG_W] = tb_ + 8'(i);
      if (drv[i] && bus.src_ready[i] && !fl) begin
        acc[i] = 1'b1;
        if (rec) sbq[i].push_back({vb + 32'(i), pb + 32'(4*i), tb_ + 8'(i)});
      end
    end
  endtask
  task automatic idle();
    cyc(4'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() != 0 || bus.cdb_valid) && n < 50) begin
      idle();
      n++;
    end
    chk(tag, 80'(n < 50), 80'(1));
  endtask
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.cdb_valid === 1'b1) begin
      got.push_back(bus.cdb_src);
      if (sbq[bus.cdb_src].size() == 0) chk("cdb_spurious", 80'(sbq[bus.cdb_src].size()), 80'(1));
      else chk("cdb_data", {bus.cdb_value, bus.cdb_pc, bus.cdb_tag}, 80'(sbq[bus.cdb_src].pop_front()));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.src_valid = '0;
    bus.src_value = '0;
    bus.src_pc = '0;
    bus.src_tag = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", 80'(bus.cdb_valid), 80'(0));
    chk("rst_value", 80'(bus.cdb_value), 80'(0));
    chk("rst_pc", 80'(bus.cdb_pc), 80'(0));
    chk("rst_tag", 80'(bus.cdb_tag), 80'(0));
    chk("rst_src", 80'(bus.cdb_src), 80'(0));
    chk("rst_ready", 80'(bus.src_ready), 80'(4'hF));
    chk("rst_err", 80'(err_overflow), 80'(0));
    @(negedge clk) reset = 1'b1;
    // single ALU result: two-cycle latency, one-cycle broadcast
    cyc(4'b0001, 1'b0, 1'b1, 1'b1, 32'h11, 32'h100, 8'h05);
    idle();
    chk("lat_early", 80'(bus.cdb_valid), 80'(0));
    idle();
    chk("lat_valid", 80'(bus.cdb_valid), 80'(1));
    chk("lat_value", 80'(bus.cdb_value), 80'(32'h11));
    chk("lat_pc", 80'(bus.cdb_pc), 80'(32'h100));
    chk("lat_tag", 80'(bus.cdb_tag), 80'(8'h05));
    chk("lat_src", 80'(bus.cdb_src), 80'(0));
    idle();
    chk("lat_one_cycle", 80'(bus.cdb_valid), 80'(0));
    // flush restores ALU-first priority, then all four at once
    cyc(4'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    cyc(4'b1111, 1'b0, 1'b1, 1'b1, 32'h1, 32'h200, 8'h10);
    idle();
    chk("all4_idle", 80'(bus.cdb_valid), 80'(0));
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("all4_valid", 80'(bus.cdb_valid), 80'(1));
      chk("all4_src", 80'(bus.cdb_src), 80'(i));
      chk("all4_value", 80'(bus.cdb_value), 80'(i + 1));
    end
    idle();
    chk("all4_done", 80'(bus.cdb_valid), 80'(0));
    got.delete();
    // contention with MUL backpressure
    mul_n = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(4'b0011 | (mul_n < 3 ? 4'b0100 : 4'b0000), 1'b0, 1'b1, 1'b1, 32'h300 + 32'(16*i), 32'h3000 + 32'(64*i), 8'(32 + 4*i));
      mul_n += int'(acc[2]);
      if (i == 2) chk("mul_full", 80'(bus.src_ready[2]), 80'(0));
    end
    idle();
    drain("drain_rr");
    chk("mul_accepted", 80'(mul_n), 80'(3));
    chk("rr_g0", 80'(got[0]), 80'(0));
    chk("rr_g1", 80'(got[1]), 80'(1));
    chk("rr_g2", 80'(got[2]), 80'(2));
    chk("rr_no_err", 80'(err_overflow), 80'(0));
    // DIV overflow is dropped and sticky
    cyc(4'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    cyc(4'b1001, 1'b0, 1'b1, 1'b1, 32'hA0, 32'h400, 8'h40);
    cyc(4'b1000, 1'b0, 1'b1, 1'b1, 32'hB0, 32'h500, 8'h50);
    cyc(4'b1000, 1'b0, 1'b0, 1'b1, 32'hDE, 32'hDE0, 8'hDE);
    chk("div_full", 80'(bus.src_ready[3]), 80'(0));
    idle();
    chk("ovf_set", 80'(err_overflow), 80'(1));
    drain("drain_ovf");
    chk("ovf_sticky", 80'(err_overflow), 80'(1));
    // flush discards queued results and a same-cycle input
    cyc(4'b0111, 1'b0, 1'b1, 1'b0, 32'hC0, 32'h600, 8'h60);
    cyc(4'b0001, 1'b1, 1'b0, 1'b0, 32'hC8, 32'h680, 8'h68);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("flush_quiet", 80'(bus.cdb_valid), 80'(0));
    end
    chk("flush_keeps_err", 80'(err_overflow), 80'(1));
    got.delete();
    cyc(4'b0011, 1'b0, 1'b1, 1'b1, 32'hD0, 32'h700, 8'h70);
    drain("drain_flush");
    chk("flush_cnt", 80'(got.size()), 80'(2));
    chk("flush_first", 80'(got[0]), 80'(0));
    // asynchronous reset mid-burst
    cyc(4'b1111, 1'b0, 1'b1, 1'b1, 32'hE0, 32'h800, 8'h80);
    idle();
    idle();
    chk("burst_live", 80'(bus.cdb_valid), 80'(1));
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) sbq[i].delete();
    #1;
    chk("arst_valid", 80'(bus.cdb_valid), 80'(0));
    chk("arst_value", 80'(bus.cdb_value), 80'(0));
    chk("arst_pc", 80'(bus.cdb_pc), 80'(0));
    chk("arst_tag", 80'(bus.cdb_tag), 80'(0));
    chk("arst_src", 80'(bus.cdb_src), 80'(0));
    chk("arst_ready", 80'(bus.src_ready), 80'(4'hF));
    chk("arst_err", 80'(err_overflow), 80'(0));
    @(negedge clk) reset = 1'b1;
`ifdef CDB_PERF_EN
    cyc(4'b1111, 1'b0, 1'b1, 1'b1, 32'hF0, 32'h900, 8'h90);
    cyc(4'b0011, 1'b0, 1'b1, 1'b1, 32'hF8, 32'h980, 8'h98);
    drain("drain_perf");
    chk("perf_conflict", 80'(perf_conflict), 80'(5));
    chk("perf_stall", 80'(perf_stall), 80'(0));
`endif
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
